// File: rtl/stream_mux_pkg.sv
// stream_mux shared types and helpers.
// Arbitration mode encoding and the channel-index width function.
package stream_mux_pkg;

    typedef logic [0:0] arb_mode_t;

    localparam arb_mode_t ARB_FIXED = 1'b0;
    localparam arb_mode_t ARB_RR    = 1'b1;

    // Channel index width, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_if.sv
// N-channel input bundle plus single registered output stream.
// slave = the mux, master = producers/consumer environment.
interface stream_mux_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    localparam int CW   = stream_mux_pkg::clog2_min1(NCH)
);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_last;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_last;
    logic [CW-1:0]        out_ch;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_ch
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter: fixed-priority or round-robin,
// with a lock override that pins the grant to one channel.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int        NCH      = 4,
    parameter arb_mode_t ARB_MODE = ARB_RR,
    localparam int       CW       = clog2_min1(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    input  logic           lock_i,
    input  logic [CW-1:0]  lock_ch_i,
    output logic [NCH-1:0] grant_o,
    output logic [CW-1:0]  gidx_o
);

    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    logic [CW-1:0] cand;
    logic          found;

    // Pick one channel; round-robin walks upward from ptr with explicit wrap.
    always_comb begin
        grant_o = '0;
        gidx_o  = '0;
        found   = 1'b0;
        cand    = ptr_i;
        if (lock_i) begin
            grant_o[lock_ch_i] = 1'b1;
            gidx_o             = lock_ch_i;
        end else if (ARB_MODE == ARB_FIXED) begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && req_i[i]) begin
                    found      = 1'b1;
                    grant_o[i] = 1'b1;
                    gidx_o     = CW'(i);
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && req_i[cand]) begin
                    found         = 1'b1;
                    grant_o[cand] = 1'b1;
                    gidx_o        = cand;
                end
                cand = (cand == LAST) ? '0 : cand + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream mux with one registered output stage,
// fixed or round-robin arbitration and optional packet locking.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int        WIDTH    = 32,
    parameter int        NCH      = 4,
    parameter arb_mode_t ARB_MODE = ARB_RR,
    parameter bit        PKT_LOCK = 1'b1,
    localparam int       CW       = clog2_min1(NCH)
) (
    input  logic         clk,
    input  logic         rst_n,
    stream_mux_if.slave  bus
);

    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [CW-1:0]    out_ch_q, out_ch_d;
    logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [CW-1:0]    lock_ch_q, lock_ch_d;

    logic [NCH-1:0]   grant;
    logic [CW-1:0]    gidx;
    logic [NCH-1:0]   in_ready;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    rr_arbiter #(
        .NCH      (NCH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req_i     (bus.in_valid),
        .ptr_i     (rr_ptr_q),
        .lock_i    (lock_q),
        .lock_ch_i (lock_ch_q),
        .grant_o   (grant),
        .gidx_o    (gidx)
    );

    // Handshake: only the granted channel sees ready, and only when
    // the output register can take a beat.
    always_comb begin
        load     = ~out_valid_q | bus.out_ready;
        in_ready = (rst_n && load) ? grant : '0;
        xfer     = |(bus.in_valid & in_ready);
        sel_data = bus.in_data[gidx*WIDTH +: WIDTH];
        sel_last = bus.in_last[gidx];
    end

    // Next state for output register, round-robin pointer and lock.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        if (load) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d = sel_data;
            out_last_d = sel_last;
            out_ch_d   = gidx;
            if (ARB_MODE == ARB_RR && (!PKT_LOCK || sel_last)) begin
                rr_ptr_d = (gidx == LAST) ? '0 : gidx + CW'(1);
            end
            if (PKT_LOCK) begin
                if (!lock_q && !sel_last) begin
                    lock_d    = 1'b1;
                    lock_ch_d = gidx;
                end else if (lock_q && sel_last) begin
                    lock_d = 1'b0;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: round-robin/locking, fixed priority,
// and a 3-channel instance for non-power-of-2 wrap.
module tb_stream_mux;
    import stream_mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_mux_if #(.WIDTH(32), .NCH(4)) bus_rr ();
    stream_mux_if #(.WIDTH(32), .NCH(4)) bus_fx ();
    stream_mux_if #(.WIDTH(32), .NCH(3)) bus_n3 ();

    stream_mux #(.WIDTH(32), .NCH(4), .ARB_MODE(ARB_RR), .PKT_LOCK(1'b1))
        u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
    stream_mux #(.WIDTH(32), .NCH(4), .ARB_MODE(ARB_FIXED), .PKT_LOCK(1'b0))
        u_fx (.clk(clk), .rst_n(rst_n), .bus(bus_fx));
    stream_mux #(.WIDTH(32), .NCH(3), .ARB_MODE(ARB_RR), .PKT_LOCK(1'b0))
        u_n3 (.clk(clk), .rst_n(rst_n), .bus(bus_n3));

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  ch;
        logic [31:0] dat;
        logic        olast;
    } vec_t;

    vec_t tbl [21];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mkdata(input int beat);
        logic [127:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'(k*256 + beat);
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          vld      lst      ordy rdy      ov ch  dat        olast
        tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 0, 0, 32'h000, 0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1, 0, 32'h000, 1};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1, 1, 32'h101, 1};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1, 2, 32'h202, 1};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1, 3, 32'h303, 1};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1, 0, 32'h004, 1};
        tbl[6]  = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1, 1, 32'h105, 1};
        tbl[7]  = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 1, 2, 32'h206, 1};
        tbl[8]  = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 1, 2, 32'h206, 1};
        tbl[9]  = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 1, 2, 32'h206, 1};
        tbl[10] = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 1, 2, 32'h206, 1};
        tbl[11] = '{4'b0100, 4'b1111, 1'b0, 4'b0000, 1, 2, 32'h206, 1};
        tbl[12] = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1, 2, 32'h206, 1};
        tbl[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1, 2, 32'h20C, 1};
        tbl[14] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 0, 2, 32'h20C, 1};
        tbl[15] = '{4'b0011, 4'b0010, 1'b1, 4'b0001, 0, 2, 32'h20C, 1};
        tbl[16] = '{4'b0011, 4'b0010, 1'b1, 4'b0001, 1, 0, 32'h00F, 0};
        tbl[17] = '{4'b0010, 4'b0010, 1'b1, 4'b0001, 1, 0, 32'h010, 0};
        tbl[18] = '{4'b0011, 4'b0011, 1'b1, 4'b0001, 0, 0, 32'h010, 0};
        tbl[19] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1, 0, 32'h012, 1};
        tbl[20] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1, 1, 32'h113, 1};

        bus_rr.in_valid = 4'b1111;
        bus_rr.in_last = 4'b1111;
        bus_rr.in_data = mkdata(0);
        bus_rr.out_ready = 1'b1;
        bus_fx.in_valid = 4'b0000;
        bus_fx.in_last = 4'b0000;
        bus_fx.in_data = mkdata(0);
        bus_fx.out_ready = 1'b1;
        bus_n3.in_valid = 3'b111;
        bus_n3.in_last = 3'b111;
        bus_n3.in_data = 96'h0;
        bus_n3.out_ready = 1'b1;

        // Reset hold with all channels requesting.
        repeat (3) step();
        chk("rst in_ready", 32'(bus_rr.in_ready), 32'h0);
        chk("rst out_valid", 32'(bus_rr.out_valid), 32'h0);
        chk("rst out_ch", 32'(bus_rr.out_ch), 32'h0);
        chk("rst out_data", bus_rr.out_data, 32'h0);
        rst_n = 1'b1;

        // Table: RR fairness, backpressure, packet lock with gap.
        for (int r = 0; r < 21; r++) begin
            bus_rr.in_valid = tbl[r].vld;
            bus_rr.in_last = tbl[r].lst;
            bus_rr.out_ready = tbl[r].ordy;
            bus_rr.in_data = mkdata(r);
            #1;
            chk($sformatf("r%0d in_ready", r),
                32'(bus_rr.in_ready), 32'(tbl[r].rdy));
            chk($sformatf("r%0d out_valid", r),
                32'(bus_rr.out_valid), 32'(tbl[r].ov));
            chk($sformatf("r%0d out_ch", r),
                32'(bus_rr.out_ch), 32'(tbl[r].ch));
            chk($sformatf("r%0d out_data", r),
                bus_rr.out_data, tbl[r].dat);
            chk($sformatf("r%0d out_last", r),
                32'(bus_rr.out_last), 32'(tbl[r].olast));
            if (r < 6) begin
                chk($sformatf("n3 r%0d in_ready", r),
                    32'(bus_n3.in_ready), 32'(3'b001 << (r % 3)));
            end
            step();
        end

        // Reset in the middle of a ch2 packet.
        bus_rr.in_valid = 4'b0100;
        bus_rr.in_last = 4'b0000;
        bus_rr.out_ready = 1'b1;
        bus_rr.in_data = mkdata(8'h21);
        #1;
        chk("mp beat1 in_ready", 32'(bus_rr.in_ready), 32'h4);
        step();
        bus_rr.in_data = mkdata(8'h22);
        #1;
        chk("mp beat1 out_data", bus_rr.out_data, 32'h221);
        chk("mp beat1 out_last", 32'(bus_rr.out_last), 32'h0);
        chk("mp locked in_ready", 32'(bus_rr.in_ready), 32'h4);
        step();
        chk("mp beat2 out_data", bus_rr.out_data, 32'h222);
        rst_n = 1'b0;
        bus_rr.in_valid = 4'b1111;
        bus_rr.in_last = 4'b1111;
        #1;
        chk("mp rst in_ready", 32'(bus_rr.in_ready), 32'h0);
        chk("mp rst out_valid", 32'(bus_rr.out_valid), 32'h0);
        chk("mp rst out_data", bus_rr.out_data, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mp release in_ready", 32'(bus_rr.in_ready), 32'h1);
        step();
        chk("mp release out_valid", 32'(bus_rr.out_valid), 32'h1);
        chk("mp release out_ch", 32'(bus_rr.out_ch), 32'h0);

        // Fixed priority, no locking even with last=0.
        bus_fx.in_valid = 4'b1010;
        bus_fx.in_last = 4'b0000;
        bus_fx.in_data = mkdata(8'h30);
        #1;
        chk("fx ch1 in_ready", 32'(bus_fx.in_ready), 32'h2);
        step();
        bus_fx.in_data = mkdata(8'h31);
        #1;
        chk("fx ch1 out_ch", 32'(bus_fx.out_ch), 32'h1);
        chk("fx ch1 out_data", bus_fx.out_data, 32'h130);
        chk("fx ch1 again in_ready", 32'(bus_fx.in_ready), 32'h2);
        step();
        bus_fx.in_valid = 4'b1000;
        bus_fx.in_data = mkdata(8'h32);
        #1;
        chk("fx ch3 in_ready", 32'(bus_fx.in_ready), 32'h8);
        chk("fx ch1 beat2 out_data", bus_fx.out_data, 32'h131);
        step();
        chk("fx ch3 out_valid", 32'(bus_fx.out_valid), 32'h1);
        chk("fx ch3 out_ch", 32'(bus_fx.out_ch), 32'h3);
        chk("fx ch3 out_data", bus_fx.out_data, 32'h332);
        chk("fx ch3 out_last", 32'(bus_fx.out_last), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
